// File: rtl/lifting_dwt_stage.sv
// One-level streaming 1-D integer lifting wavelet stage.
// MODE 0: Haar S-transform, MODE 1: LeGall 5/3 reversible with symmetric
// extension at both frame edges. Each frame of FRAME_LEN samples yields
// FRAME_LEN/2 (approximation, detail) pairs through a single output register.
module lifting_dwt_stage #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 256,
  parameter int MODE      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W:0]   out_a,
  output logic signed [DATA_W:0]   out_d,
  output logic                     out_last
);

  localparam int W1 = DATA_W + 1;
  localparam int W2 = DATA_W + 2;
  localparam int KW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);
  localparam logic [KW-1:0] K_TWO  = KW'(2);
  localparam logic signed [W2-1:0] RND = W2'(2);

  typedef enum logic [1:0] {S_X0, S_ODD, S_EVEN} state_t;

  typedef struct packed {
    logic signed [W1-1:0] a;
    logic signed [W1-1:0] d;
    logic                 last;
  } pair_t;

  state_t                   state;
  logic [KW-1:0]            k;
  logic signed [DATA_W-1:0] even_q;   // x[2n], the most recent even sample
  logic signed [DATA_W-1:0] odd_q;    // x[2n+1], held until x[2n+2] arrives
  logic signed [W1-1:0]     d_prev;   // d[n-1] for the 5/3 update step

  logic signed [W2-1:0] xe, xo, xe2;
  logic signed [W2-1:0] hd, ha, ld, dp, la;
  logic                 in_hs, emit, is_last;
  pair_t                nxt;

  // A stalled pair blocks every input so the handshake looks the same for all samples.
  assign in_ready = !out_valid || out_ready;
  assign in_hs    = in_valid && in_ready;

  // Lifting datapath for both kernels, evaluated against the sample on in_data.
  always_comb begin
    xe  = {{2{even_q[DATA_W-1]}}, even_q};
    xo  = {{2{in_data[DATA_W-1]}}, in_data};
    xe2 = xe;                       // right mirror: x[FRAME_LEN] = x[FRAME_LEN-2]
    if (state == S_EVEN) begin
      xo  = {{2{odd_q[DATA_W-1]}}, odd_q};
      xe2 = {{2{in_data[DATA_W-1]}}, in_data};
    end
    hd = xo - xe;
    ha = xe + (hd >>> 1);
    ld = xo - ((xe + xe2) >>> 1);
    // left mirror: the first pair of a frame uses d[-1] = d[0]
    dp = (state == S_EVEN && k == K_TWO) ? ld : {d_prev[W1-1], d_prev};
    la = xe + ((dp + ld + RND) >>> 2);
    is_last = (state == S_ODD) && (k == K_LAST);
    if (MODE == 0) emit = (state == S_ODD);
    else           emit = (state == S_EVEN) || is_last;
    nxt.a    = (MODE == 0) ? W1'(ha) : W1'(la);
    nxt.d    = (MODE == 0) ? W1'(hd) : W1'(ld);
    nxt.last = is_last;
  end

  // Phase FSM, sample counter and held lifting history; advances only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_X0;
      k      <= '0;
      even_q <= '0;
      odd_q  <= '0;
      d_prev <= '0;
    end else if (in_hs) begin
      case (state)
        S_X0: begin
          even_q <= in_data;
          k      <= KW'(1);
          state  <= S_ODD;
        end
        S_ODD: begin
          odd_q <= in_data;
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_X0;
          end else begin
            k     <= k + 1'b1;
            state <= S_EVEN;
          end
        end
        S_EVEN: begin
          even_q <= in_data;
          d_prev <= W1'(ld);
          k      <= k + 1'b1;
          state  <= S_ODD;
        end
        default: state <= S_X0;
      endcase
    end
  end

  // Output register: reload on a producing accept, otherwise drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_d     <= '0;
      out_last  <= 1'b0;
    end else if (in_hs && emit) begin
      out_valid <= 1'b1;
      out_a     <= nxt.a;
      out_d     <= nxt.d;
      out_last  <= nxt.last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lifting_dwt_stage.sv
// Directed bench for lifting_dwt_stage: three instances (Haar/4, 5/3/4, 5/3/8)
// share one input bus; expected pairs are queued when frames are driven and
// popped whenever an instance completes an output handshake.
module tb_lifting_dwt_stage;

  logic clk, rst_n, orr;
  logic [2:0] iv, ir, ov, ol;
  logic signed [15:0] din;
  logic signed [16:0] oa [3];
  logic signed [16:0] od [3];

  lifting_dwt_stage #(.DATA_W(16), .FRAME_LEN(4), .MODE(0)) u_haar (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din),
    .out_valid(ov[0]), .out_ready(orr), .out_a(oa[0]), .out_d(od[0]), .out_last(ol[0]));
  lifting_dwt_stage #(.DATA_W(16), .FRAME_LEN(4), .MODE(1)) u_lg (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din),
    .out_valid(ov[1]), .out_ready(orr), .out_a(oa[1]), .out_d(od[1]), .out_last(ol[1]));
  lifting_dwt_stage #(.DATA_W(16), .FRAME_LEN(8), .MODE(1)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din),
    .out_valid(ov[2]), .out_ready(orr), .out_a(oa[2]), .out_d(od[2]), .out_last(ol[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int a; int d; int last;} exp_t;
  exp_t q0[$], q1[$], q2[$];

  int checks = 0, failures = 0;
  int cyc = 0, stall_left = 0;
  int sa[3], sd[3], sl[3];
  bit pb[3];

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(int sel, int a, int d, int last);
    exp_t e;
    e.a = a; e.d = d; e.last = last;
    case (sel)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(int sel);
    case (sel)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Reference model over a whole frame, straight from the lifting equations.
  task automatic model_push(int sel, int len, int mode, int x[8]);
    int d[4];
    int xn2, dpv, a;
    for (int n = 0; n < len/2; n++) begin
      if (mode == 0) begin
        d[n] = x[2*n+1] - x[2*n];
        push(sel, x[2*n] + (d[n] >>> 1), d[n], int'(n == len/2-1));
      end else begin
        xn2 = (2*n+2 < len) ? x[2*n+2] : x[len-2];
        d[n] = x[2*n+1] - ((x[2*n] + xn2) >>> 1);
      end
    end
    if (mode == 1)
      for (int n = 0; n < len/2; n++) begin
        dpv = (n == 0) ? d[0] : d[n-1];
        a = x[2*n] + ((dpv + d[n] + 2) >>> 2);
        push(sel, a, d[n], int'(n == len/2-1));
      end
  endtask

  // Observe all instances; a valid&&ready seen here completes at the next posedge.
  task automatic monitor();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && orr) begin
        if (qsize(i) == 0) begin
          chk($sformatf("unexpected_pair_u%0d", i), 1, 0);
        end else begin
          case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("a_u%0d", i), int'(oa[i]), e.a);
          chk($sformatf("d_u%0d", i), int'(od[i]), e.d);
          chk($sformatf("last_u%0d", i), int'(ol[i]), e.last);
        end
      end
      if (ov[i] && !orr) begin
        chk($sformatf("in_ready_blocked_u%0d", i), int'(ir[i]), 0);
        if (pb[i]) begin
          chk($sformatf("hold_a_u%0d", i), int'(oa[i]), sa[i]);
          chk($sformatf("hold_d_u%0d", i), int'(od[i]), sd[i]);
          chk($sformatf("hold_last_u%0d", i), int'(ol[i]), sl[i]);
        end
        sa[i] = int'(oa[i]); sd[i] = int'(od[i]); sl[i] = int'(ol[i]);
      end
      pb[i] = ov[i] && !orr;
    end
  endtask

  task automatic cycle(input bit v, input int sel, input int x, output bit acc);
    @(negedge clk);
    iv  = v ? 3'(1 << sel) : 3'b000;
    din = 16'(x);
    orr = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    #2;
    acc = v && ir[sel];
    monitor();
    @(posedge clk);
    cyc++;
  endtask

  task automatic send(int sel, int x);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 40) begin
      cycle(1'b1, sel, x, acc);
      n++;
    end
    chk($sformatf("accept_u%0d_x%0d", sel, x), int'(acc), 1);
  endtask

  task automatic idle(int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, acc);
  endtask

  task automatic send4(int sel, int x0, int x1, int x2, int x3);
    send(sel, x0); send(sel, x1); send(sel, x2); send(sel, x3);
  endtask

  task automatic check_zero(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_valid_u%0d", tag, i), int'(ov[i]), 0);
      chk($sformatf("%s_a_u%0d", tag, i), int'(oa[i]), 0);
      chk($sformatf("%s_d_u%0d", tag, i), int'(od[i]), 0);
      chk($sformatf("%s_last_u%0d", tag, i), int'(ol[i]), 0);
    end
  endtask

  initial begin
    int fr[8];
    int c0;
    rst_n = 1'b0; orr = 1'b1; iv = '0; din = '0;
    pb[0] = 0; pb[1] = 0; pb[2] = 0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("ready_after_reset_u%0d", i), int'(ir[i]), 1);

    // Haar directed frame with latency checks
    push(0, 15, 10, 0); push(0, 35, 10, 1);
    send(0, 10); #1 chk("haar_lat_x0", int'(ov[0]), 0);
    send(0, 20); #1 chk("haar_lat_x1", int'(ov[0]), 1);
    send(0, 30); #1 chk("haar_lat_x2", int'(ov[0]), 0);
    send(0, 40); #1 chk("haar_lat_x3", int'(ov[0]), 1);
    idle(2);

    // Haar signed extremes and floor behaviour
    push(0, -1, 65535, 0); push(0, 0, 7, 1);
    push(0, 0, -7, 0);     push(0, 15, 10, 1);
    send4(0, -32768, 32767, -3, 4);
    send4(0, 4, -3, 10, 20);
    idle(2);

    // 5/3 directed frame, both mirror boundaries
    push(1, 10, 0, 0); push(1, 33, 10, 1);
    send(1, 10);
    send(1, 20); #1 chk("lg_lat_x1", int'(ov[1]), 0);
    send(1, 30); #1 chk("lg_lat_x2", int'(ov[1]), 1);
    send(1, 40); #1 chk("lg_lat_x3", int'(ov[1]), 1);
    idle(2);

    // 5/3 back-to-back frames, no cross-frame history
    push(1, 10, 0, 0); push(1, 33, 10, 1);
    fr = '{40, 30, 20, 10, 0, 0, 0, 0};
    model_push(1, 4, 1, fr);
    c0 = cyc;
    send4(1, 10, 20, 30, 40);
    send4(1, 40, 30, 20, 10);
    chk("lg_b2b_cycles", cyc - c0, 8);
    idle(2);

    // Reset mid-frame with a blocked pending pair
    stall_left = 100;
    send(1, 1); send(1, 2); send(1, 3);
    @(negedge clk) rst_n = 1'b0;
    #1 check_zero("midreset");
    stall_left = 0; orr = 1'b1; iv = '0;
    pb[0] = 0; pb[1] = 0; pb[2] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_after_midreset", int'(ir[1]), 1);
    push(1, 10, 0, 0); push(1, 33, 10, 1);
    send4(1, 10, 20, 30, 40);
    idle(2);

    // FRAME_LEN=8 ramp with a 5-cycle output stall
    for (int i = 0; i < 8; i++) fr[i] = i * 100 - 300;
    model_push(2, 8, 1, fr);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) stall_left = 5;
      send(2, fr[i]);
    end
    idle(3);

    // Two random back-to-back frames at full throughput
    c0 = cyc;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = int'($urandom_range(0, 65535)) - 32768;
      model_push(2, 8, 1, fr);
      for (int i = 0; i < 8; i++) send(2, fr[i]);
    end
    chk("w_throughput_cycles", cyc - c0, 16);
    idle(3);

    for (int i = 0; i < 3; i++) chk($sformatf("leftover_u%0d", i), qsize(i), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
